// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial WIDTH-bit subtraction controller driving one
// external 1-bit full-subtractor cell, LSB first, with a start/busy/done
// handshake.
// Optional feature: define SERSUB_SIGNED_OVF_EN to add the registered
// two's-complement overflow output ovf.
//
// state  | meaning
// S_IDLE | waiting for start; result registers hold the last result
// S_RUN  | one bit per cycle through the cell, cnt counts bit steps
// S_DONE | single-cycle completion pulse; start here is accepted
module serial_sub_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             bin_in,
   output logic             fs_a,
   output logic             fs_b,
   output logic             fs_bin,
   input  logic             fs_d,
   input  logic             fs_bout,
   output logic [WIDTH-1:0] diff_out,
   output logic             borrow_out,
`ifdef SERSUB_SIGNED_OVF_EN
   output logic             ovf,
`endif
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
   logic             borrow_reg_q, borrow_reg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_out_q, diff_out_d;
   logic             borrow_out_q, borrow_out_d;
`ifdef SERSUB_SIGNED_OVF_EN
   logic             ovf_q, ovf_d;
`endif
   logic             in_run;
   logic             load;

   // Next-state and datapath: cell outputs are only sampled in S_RUN so X
   // from an idle cell never reaches a register.
   always_comb begin
      state_d      = state_q;
      a_sr_d       = a_sr_q;
      b_sr_d       = b_sr_q;
      diff_sr_d    = diff_sr_q;
      borrow_reg_d = borrow_reg_q;
      cnt_d        = cnt_q;
      diff_out_d   = diff_out_q;
      borrow_out_d = borrow_out_q;
`ifdef SERSUB_SIGNED_OVF_EN
      ovf_d        = ovf_q;
`endif
      load         = 1'b0;

      case (state_q)
         S_IDLE: begin
            load = start;
         end
         S_RUN: begin
            diff_sr_d    = {fs_d, diff_sr_q[WIDTH-1:1]};
            a_sr_d       = a_sr_q >> 1;
            b_sr_d       = b_sr_q >> 1;
            borrow_reg_d = fs_bout;
            cnt_d        = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d      = S_DONE;
               diff_out_d   = {fs_d, diff_sr_q[WIDTH-1:1]};
               borrow_out_d = fs_bout;
`ifdef SERSUB_SIGNED_OVF_EN
               // borrow into the MSB vs borrow out of it
               ovf_d        = borrow_reg_q ^ fs_bout;
`endif
            end
         end
         S_DONE: begin
            load    = start;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (load) begin
         state_d      = S_RUN;
         a_sr_d       = a_in;
         b_sr_d       = b_in;
         borrow_reg_d = bin_in;
         cnt_d        = '0;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         a_sr_q       <= '0;
         b_sr_q       <= '0;
         diff_sr_q    <= '0;
         borrow_reg_q <= 1'b0;
         cnt_q        <= '0;
         diff_out_q   <= '0;
         borrow_out_q <= 1'b0;
`ifdef SERSUB_SIGNED_OVF_EN
         ovf_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         a_sr_q       <= a_sr_d;
         b_sr_q       <= b_sr_d;
         diff_sr_q    <= diff_sr_d;
         borrow_reg_q <= borrow_reg_d;
         cnt_q        <= cnt_d;
         diff_out_q   <= diff_out_d;
         borrow_out_q <= borrow_out_d;
`ifdef SERSUB_SIGNED_OVF_EN
         ovf_q        <= ovf_d;
`endif
      end
   end

   // Cell drive and handshake outputs decoded from registers only.
   always_comb begin
      in_run     = (state_q == S_RUN);
      fs_a       = in_run & a_sr_q[0];
      fs_b       = in_run & b_sr_q[0];
      fs_bin     = in_run & borrow_reg_q;
      busy       = in_run;
      done       = (state_q == S_DONE);
      diff_out   = diff_out_q;
      borrow_out = borrow_out_q;
`ifdef SERSUB_SIGNED_OVF_EN
      ovf        = ovf_q;
`endif
   end

endmodule
